// File: rtl/btb_if.sv
// btb_if: fetch lookup and execute update ports of the branch target buffer
interface btb_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_pc;
  logic            resp_valid;
  logic            resp_hit;
  logic [XLEN-1:0] resp_target;
  logic            upd_valid;
  logic            upd_ready;
  logic [XLEN-1:0] upd_pc;
  logic            upd_v;
  logic [XLEN-1:0] upd_target;
  logic            busy;
  modport master (
    output req_valid, req_pc, upd_valid, upd_pc, upd_v, upd_target,
    input  req_ready, resp_valid, resp_hit, resp_target, upd_ready, busy
  );
  modport slave (
    input  req_valid, req_pc, upd_valid, upd_pc, upd_v, upd_target,
    output req_ready, resp_valid, resp_hit, resp_target, upd_ready, busy
  );
endinterface

// File: rtl/btb_table.sv
// btb_table: direct-mapped branch target buffer with reset clear sweep and write-first lookup
module btb_table #(
  parameter int IDX_W = 13,
  parameter int TAG_W = 8,
  parameter int XLEN  = 32
) (
  input logic clk,
  input logic rst,
  btb_if.slave bus
);
  localparam int N = 1 << IDX_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [N-1:0] v_q, v_d;
  logic [TAG_W-1:0] bia_mem [N];
  logic [XLEN-1:0] bta_mem [N];
  logic resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d;
  logic [XLEN-1:0] resp_target_q, resp_target_d;
  logic [IDX_W-1:0] req_idx, upd_idx;
  logic [TAG_W-1:0] req_tag, upd_tag;
  logic ready, req_fire, upd_fire, fwd, hit, unused_pc;
  assign req_idx = bus.req_pc[IDX_W+1:2];
  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign req_tag = bus.req_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc = ^{bus.req_pc[XLEN-1:IDX_W+TAG_W+2], bus.req_pc[1:0],
                       bus.upd_pc[XLEN-1:IDX_W+TAG_W+2], bus.upd_pc[1:0]};
  // rst gates acceptance combinationally so a reset cycle never starts a lookup or write
  assign ready = state_q == READY && !rst;
  assign req_fire = bus.req_valid && ready;
  assign upd_fire = bus.upd_valid && ready;
  assign fwd = upd_fire && upd_idx == req_idx;
  assign hit = fwd ? bus.upd_v && upd_tag == req_tag
                   : v_q[req_idx] && bia_mem[req_idx] == req_tag;
  assign bus.req_ready = ready;
  assign bus.upd_ready = ready;
  assign bus.busy = !ready;
  assign bus.resp_valid = resp_valid_q && !rst;
  assign bus.resp_hit = resp_hit_q && !rst;
  assign bus.resp_target = rst ? '0 : resp_target_q;
  always_comb begin
    v_d = v_q;
    state_d = (state_q == CLEAR && &cnt_q) ? READY : state_q;
    cnt_d = (state_q == CLEAR && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    resp_valid_d = req_fire;
    resp_hit_d = req_fire && hit;
    resp_target_d = (req_fire && hit) ? (fwd ? bus.upd_target : bta_mem[req_idx]) : '0;
    if (state_q == CLEAR) v_d[cnt_q] = 1'b0;
    if (upd_fire) v_d[upd_idx] = bus.upd_v;
  end
  always_ff @(posedge clk) begin
    v_q <= v_d;
    if (rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q <= 1'b0;
      resp_target_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q <= resp_hit_d;
      resp_target_q <= resp_target_d;
    end
  end
  always_ff @(posedge clk) begin
    if (upd_fire) begin
      bia_mem[upd_idx] <= upd_tag;
      bta_mem[upd_idx] <= bus.upd_target;
    end
  end
endmodule

// File: tb/tb_btb_table.sv
// tb_btb_table: scoreboard bench for btb_table with a 16-entry table
module tb_btb_table;
  localparam int IDX_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  btb_if #(.XLEN(32)) bus();
  btb_table #(.IDX_W(IDX_W), .TAG_W(8), .XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int due;
    logic hit;
    logic [31:0] tgt;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // expected responses are due one cycle after the edge that accepted their request
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      total += 3;
      if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL resp_valid got=%b want=1", bus.resp_valid); end
      if (bus.resp_hit !== e.hit) begin bad++; $display("FAIL resp_hit got=%b want=%b", bus.resp_hit, e.hit); end
      if (bus.resp_target !== e.tgt) begin bad++; $display("FAIL resp_target got=%h want=%h", bus.resp_target, e.tgt); end
    end else begin
      total++;
      if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL idle_resp_valid got=%b want=0 cyc=%0d", bus.resp_valid, cyc); end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.req_valid = 1'b0;
    bus.upd_valid = 1'b0;
  endtask
  task automatic req(input logic [31:0] pc);
    bus.req_valid = 1'b1;
    bus.req_pc = pc;
  endtask
  task automatic upd(input logic [31:0] pc, input logic v, input logic [31:0] tgt);
    bus.upd_valid = 1'b1;
    bus.upd_pc = pc;
    bus.upd_v = v;
    bus.upd_target = tgt;
  endtask
  task automatic push(input logic hit, input logic [31:0] tgt);
    q.push_back('{cyc + 1, hit, tgt});
  endtask
  task automatic wait_sweep(output int n, output int rdy_bad);
    n = 0;
    rdy_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      n++;
      if (bus.req_ready !== 1'b0 || bus.upd_ready !== 1'b0) rdy_bad++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    int n, rb;
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    wait_sweep(n, rb);
    total++;
    if (n !== 16) begin bad++; $display("FAIL sweep_len got=%0d want=16", n); end
    total++;
    if (rb !== 0) begin bad++; $display("FAIL ready_in_clear got=%0d cycles want=0", rb); end
    total++;
    if (bus.req_ready !== 1'b1 || bus.upd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_sweep got=%b%b%b want=110", bus.req_ready, bus.upd_ready, bus.busy);
    end
    req(32'h8000_0000); push(1'b0, 32'h0); step();
    idle(); step();
  endtask
  task automatic test_update_lookup();
    upd(32'h8000_0010, 1'b1, 32'h8000_0100); step();
    idle();
    req(32'h8000_0010); push(1'b1, 32'h8000_0100); step();
    req(32'h8000_0050); push(1'b0, 32'h0); step();
    idle(); step();
  endtask
  task automatic test_write_first();
    upd(32'h8000_0020, 1'b1, 32'h8000_02A0); req(32'h8000_0020); push(1'b1, 32'h8000_02A0); step();
    upd(32'h8000_0020, 1'b0, 32'h8000_02A0); req(32'h8000_0020); push(1'b0, 32'h0); step();
    idle();
    upd(32'h8000_0020, 1'b1, 32'h8000_02A0); step();
    upd(32'h8000_0060, 1'b1, 32'h1234_5678); req(32'h8000_0020); push(1'b0, 32'h0); step();
    idle();
    req(32'h8000_0060); push(1'b1, 32'h1234_5678); step();
    idle(); step();
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      upd(32'(i * 4), 1'b1, 32'(32'h1000 * (i + 1)));
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      req(32'(i * 4));
      push(1'b1, 32'(32'h1000 * (i + 1)));
      step();
    end
    idle(); step();
  endtask
  task automatic test_reset_mid();
    int n, rb;
    req(32'h8000_0010); step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_sweep(n, rb);
    total++;
    if (n !== 16) begin bad++; $display("FAIL mid_sweep_len got=%0d want=16", n); end
    req(32'h8000_0010); push(1'b0, 32'h0); step();
    req(32'h8000_0060); push(1'b0, 32'h0); step();
    for (int i = 0; i < 4; i++) begin
      req(32'(i * 4));
      push(1'b0, 32'h0);
      step();
    end
    idle(); step();
  endtask
  task automatic test_clear_requests();
    int bb = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    upd(32'h8000_0010, 1'b1, 32'hDEAD_0000);
    req(32'h8000_0010);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) bb++;
      @(posedge clk);
      #1;
    end
    idle();
    total++;
    if (bb !== 0) begin bad++; $display("FAIL clear_busy got=%0d low cycles want=0", bb); end
    total++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL clear_done got busy=%b ready=%b want busy=0 ready=1", bus.busy, bus.req_ready);
    end
    req(32'h8000_0010); push(1'b0, 32'h0); step();
    idle(); step();
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_pc = '0;
    bus.upd_valid = 1'b0;
    bus.upd_pc = '0;
    bus.upd_v = 1'b0;
    bus.upd_target = '0;
    test_reset();
    test_update_lookup();
    test_write_first();
    test_back_to_back();
    test_reset_mid();
    test_clear_requests();
    step();
    step();
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL pending_resp got=%0d want=0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/btb_table.md
Name: btb_table

Overview:
- Synthesizable branch target buffer storage that replaces the simulation-only DPI entry store.
- Fetch side issues lookups by PC and receives hit/target one cycle later.
- Execute side writes allocate/update entries.
- Same entry format as the existing BTB interface: valid bit V, 8-bit tag BIA, 32-bit target BTA, direct-mapped by PC index.

Parameters:
IDX_W, 13, index width; entry count = 2^IDX_W
TAG_W, 8, tag (BIA) width
XLEN, 32, PC/target width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  fetch lookup request
req_ready  output  1  table can accept a lookup (READY state)
req_pc  input  XLEN  fetch PC
resp_valid  output  1  lookup result valid (one cycle after accepted request)
resp_hit  output  1  entry valid and tag match
resp_target  output  XLEN  predicted target (BTA); 0 when no hit
upd_valid  input  1  execute-side write request
upd_ready  output  1  write can be accepted (READY state)
upd_pc  input  XLEN  branch PC being written
upd_v  input  1  valid bit to store (0 = invalidate)
upd_target  input  XLEN  target to store
busy  output  1  high during clear sweep

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] ignored.
- Storage: V array (flops), BIA array, BTA array. BIA/BTA contents are don't-care while V=0.
- FSM states: CLEAR, READY.
  - rst=1 in any cycle → CLEAR, sweep counter=0. This aborts any lookup or sweep in flight; the aborted lookup produces no resp_valid.
  - CLEAR: each cycle, V[counter] cleared and counter+1. On clearing entry 2^IDX_W-1 → READY. The sweep takes exactly 2^IDX_W cycles after rst drops.
  - READY: stays until rst.
- Output values:
  - CLEAR: req_ready=0, upd_ready=0, busy=1.
  - READY: req_ready=1, upd_ready=1, busy=0.
  - During rst and CLEAR: resp_valid=0, resp_hit=0, resp_target=0.
- Lookup:
  - Accepted when req_valid & req_ready.
  - Result registered: resp_valid=1 in the next cycle only, for exactly one cycle per accepted request.
  - A request can be accepted every cycle (fully pipelined, no backpressure on resp).
  - resp_hit = V[idx] & (BIA[idx]==tag). resp_target = BTA[idx] when hit, else 0.
- Update:
  - Accepted when upd_valid & upd_ready.
  - Writes V[idx]=upd_v, BIA[idx]=tag(upd_pc), BTA[idx]=upd_target at that edge.
- Simultaneous lookup and update to the same index in the same cycle: write-first. The lookup response reflects the new values.
  - Example: upd_v=0 yields resp_hit=0.
  - A different tag at the same index yields a miss for the old tag.
- Lookup in the cycle after an update sees the updated entry, as a normal read.
- upd_valid or req_valid during CLEAR: ignored, no side effect. The requester must hold the request until ready.
- No wrap/overflow: the sweep counter is IDX_W+1 bits wide, or stops on the terminal index.

Test Plan (IDX_W=4 for sim speed):
- Reset sweep: rst pulsed 1 cycle → busy=1 and req_ready=0 for exactly 16 cycles, then busy=0. A lookup of pc=0x80000000 gives resp_valid=1, resp_hit=0, resp_target=0 next cycle.
- Update then lookup: upd pc=0x80000010, v=1, target=0x80000100. Next cycle lookup pc=0x80000010 → resp_hit=1, resp_target=0x80000100. Lookup pc=0x80000050 (same index, different tag) → resp_hit=0.
- Same-cycle write-first: cycle N, update pc=0x80000020 with target 0x800002A0 and lookup of pc=0x80000020 → N+1 shows resp_hit=1, resp_target=0x800002A0. Repeat with upd_v=0 → resp_hit=0.
- Back-to-back lookups: req_valid held 4 cycles on pcs 0x0, 0x4, 0x8, 0xC after distinct updates → 4 consecutive resp_valid cycles in order with matching targets.
- Reset mid-operation: rst asserted in the cycle after an accepted lookup → no resp_valid. After the 16-cycle sweep, all previously written entries miss.
- Requests during CLEAR: upd_valid=1 for pc=0x80000010 throughout the sweep → no write. A lookup after READY misses.
